// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode encodings, default output width and the
// pointer-width helper used by the result buffer.
package cordic_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_VEC  = 2'd1,
        MODE_ROT  = 2'd2
    } cordic_mode_e;

    localparam int CORDIC_OUT_WIDTH = 16;

    // Pointers carry one extra wrap bit above the slot index.
    function automatic int resbuf_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cordic_result_buf.sv
// In-order result holding buffer behind the CORDIC; reserves a slot per issue
// and returns credit. Optional sticky protocol error via CORDIC_RESBUF_ERR_EN.
module cordic_result_buf
    import cordic_pkg::*;
#(
    parameter int OUT_WIDTH = CORDIC_OUT_WIDTH,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_in,
    input  logic [1:0]           mode_in,
    input  logic                 res_valid_in,
    input  logic [OUT_WIDTH-1:0] res_r_in,
    input  logic [OUT_WIDTH-1:0] res_a_in,
    output logic                 credit_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_r,
    output logic [OUT_WIDTH-1:0] out_a,
    output logic [1:0]           out_mode,
    output logic                 err_out
);

    localparam int PW = resbuf_ptr_w(DEPTH);
    localparam int IW = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef struct packed {
        logic [1:0]           mode;
        logic [OUT_WIDTH-1:0] a;
        logic [OUT_WIDTH-1:0] r;
    } slot_t;

    slot_t slots [DEPTH];

    logic [PW-1:0] iss_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;

    logic do_issue;
    logic do_fill;
    logic do_pop;
    logic has_reserved;

    assign used         = iss_ptr - rd_ptr;
    assign credit_out   = (used < DEPTH_P);
    assign has_reserved = (fill_ptr != iss_ptr);
    assign out_valid    = (fill_ptr != rd_ptr);

    assign do_issue = issue_in & credit_out;
    assign do_fill  = res_valid_in & has_reserved;
    assign do_pop   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_ptr  <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
        end else begin
            if (do_issue) iss_ptr  <= iss_ptr + 1'b1;
            if (do_fill)  fill_ptr <= fill_ptr + 1'b1;
            if (do_pop)   rd_ptr   <= rd_ptr + 1'b1;
        end
    end

    // Issue and fill never target the same slot: a fill needs fill_ptr != iss_ptr.
    always_ff @(posedge clk) begin
        if (do_issue) slots[iss_ptr[IW-1:0]].mode <= mode_in;
        if (do_fill) begin
            slots[fill_ptr[IW-1:0]].r <= res_r_in;
            slots[fill_ptr[IW-1:0]].a <= res_a_in;
        end
    end

    always_comb begin
        out_r    = '0;
        out_a    = '0;
        out_mode = '0;
        if (out_valid) begin
            out_r    = slots[rd_ptr[IW-1:0]].r;
            out_a    = slots[rd_ptr[IW-1:0]].a;
            out_mode = slots[rd_ptr[IW-1:0]].mode;
        end
    end

`ifdef CORDIC_RESBUF_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((issue_in & ~credit_out) | (res_valid_in & ~has_reserved)) begin
            err_q <= 1'b1;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: doc/cordic_result_buf.md
# cordic_result_buf

Result reorder/holding buffer placed directly downstream of the CORDIC top. It reserves a slot when a request is issued to the CORDIC, fills the slot when the CORDIC's fixed-latency result pulse arrives, and presents results to the consumer over a valid/ready handshake. It returns a credit to the issuer so that the CORDIC, which has no backpressure, can never produce a result with nowhere to put it.

## Interface
- `OUT_WIDTH`, 16: width of r/a result words; equal to the CORDIC output width.
- `DEPTH`, 8: slot count; power of two, minimum 2.
- `clk` in 1: clock.
- `rst` in 1: reset; one clock; asynchronous, active-high.
- `issue_in` in 1: pulse, same cycle as the CORDIC `en_in`; reserves one slot.
- `mode_in` in 2: mode sent with that issue; captured into the slot.
- `res_valid_in` in 1: CORDIC `ready_out`.
- `res_r_in` in OUT_WIDTH: CORDIC `r_out`.
- `res_a_in` in OUT_WIDTH: CORDIC `a_out`.
- `credit_out` out 1: high when a free slot exists; issue is legal only while high.
- `out_valid` out 1: head slot holds a result.
- `out_ready` in 1: consumer accepts head.
- `out_r` out OUT_WIDTH: head r.
- `out_a` out OUT_WIDTH: head a.
- `out_mode` out 2: head mode tag.
- `err_out` out 1: sticky protocol error; present only with the macro.

## Operation
- Three pointers, each log2(DEPTH)+1 bits with a wrap bit: `iss_ptr` (next slot to reserve), `fill_ptr` (next slot to fill), `rd_ptr` (head).
- Reserved slots: fill_ptr..iss_ptr-1. Filled slots: rd_ptr..fill_ptr-1.
- `credit_out = (iss_ptr - rd_ptr) < DEPTH`. This is combinational from the registered pointers.
- Issue with `issue_in & credit_out`:
  - Write `mode_in` into the slot at iss_ptr.
  - Increment iss_ptr.
  - Issues in mode 0 reserve a slot as normal.
- Result with `res_valid_in` and fill_ptr != iss_ptr:
  - Write r/a into the slot at fill_ptr.
  - Increment fill_ptr.
- Output:
  - `out_valid = (fill_ptr != rd_ptr)`.
  - On `out_valid & out_ready`, increment rd_ptr.
  - `out_r`, `out_a` and `out_mode` are driven from the slot at rd_ptr, and forced to 0 while `out_valid` is low.
- Issue, result and pop may all occur in the same cycle. Each uses the pointer values from before the edge.
- A pop in the same cycle does not make an issue legal when `credit_out` is 0.
- Illegal events:
  - `issue_in` while `credit_out`=0: ignored, no slot reserved.
  - `res_valid_in` with no reserved slot: result dropped.
  - With the macro, both set `err_out`.
- Results are in order; the CORDIC has a fixed latency, so no tag matching is needed.

## Timing
- Reset values:
  - All pointers 0.
  - `credit_out`=1, `out_valid`=0, `out_r`/`out_a`/`out_mode`=0, `err_out`=0.
  - Slot contents are don't-care.
- Reset mid-operation: all reservations are discarded. Any CORDIC result still in flight that arrives after reset is treated as unreserved: it is dropped and flags `err_out`.
- `res_valid_in` sampled at edge N gives `out_valid` high after edge N, i.e. during cycle N+1, when the buffer was empty. Fill-to-output latency is 1 cycle.
- An issue at edge N updates `credit_out` during cycle N+1.
- A pop at edge N frees its slot; `credit_out` reflects this in cycle N+1.
- Sustained throughput: one issue and one pop per cycle with `out_ready` held high.
- Full: `iss_ptr - rd_ptr == DEPTH` gives `credit_out`=0.
- Pointer wrap: when the index bits wrap, the wrap bit toggles. Comparisons use all log2(DEPTH)+1 bits.

## Configuration
- Macro `CORDIC_RESBUF_ERR_EN`.
- Defined:
  - `err_out` is set by either illegal event.
  - It is sticky until `rst`.
- Undefined:
  - `err_out` is tied to 0 and no detection logic is built.
  - Illegal events are still ignored or dropped exactly as described.

## Structure
- The shared package `cordic_pkg` holds:
  - the mode encodings `MODE_NONE`=0, `MODE_VEC`=1, `MODE_ROT`=2;
  - the default `OUT_WIDTH`;
  - the buffer pointer-width function, clog2 of DEPTH plus 1.
- Single module; slot storage is a register array `{mode, a, r}` inside it. No sub-module.

## Test plan
- Reset:
  - Assert `rst` mid-cycle with 3 slots reserved and 2 filled.
  - Required: outputs go to reset values immediately; `credit_out`=1.
  - A later `res_valid_in` is dropped; with the macro, `err_out`=1.
- Single transaction:
  - Issue mode 2, then `res_valid_in` 18 cycles later with r=0x1234, a=0xFEDC.
  - Required: next cycle `out_valid`=1, `out_r`=0x1234, `out_a`=0xFEDC, `out_mode`=2.
  - Pop clears `out_valid`.
- Fill to full:
  - With DEPTH=8 and `out_ready`=0, issue 8 times and return 8 results with r=1..8.
  - Required: `credit_out`=0 after the 8th issue.
  - A 9th issue is ignored and sets `err_out`.
  - Popping then yields r=1..8 in order.
- Full plus pop:
  - When full, issue and pop in the same cycle.
  - Required: the issue is rejected and the pop succeeds; `credit_out`=1 next cycle.
- Wrap-around:
  - Stream 20 transactions at full rate with `out_ready`=1 and random modes.
  - Required: all 20 outputs match the scoreboard; `err_out` stays 0.
- Unreserved result:
  - `res_valid_in` with nothing reserved.
  - Required: no `out_valid`. `err_out`=1 with the macro and stays 0 without it.
